// File: rtl/scd_pkg.sv
// Shared constants and types for the shift-count / floating-exponent unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Bit numbering note: the machine documents fields big-endian (bit 0 = MSB).
// RTL vectors are declared descending, so machine bit i of an N-bit field is
// vector bit N-1-i (e.g. AR[0] is ar[35], SC[0] (sign) is sc[9]).
package scd_pkg;

  localparam int W     = 10;  // SC/FE/SCAD width, two's complement
  localparam int SHMAX = 36;  // saturation limit for the shift amount

  typedef logic [W-1:0] word_t;

  // SCAD A mux select codes
  localparam logic [1:0] SCAD_A_FE    = 2'b00;
  localparam logic [1:0] SCAD_A_EXP   = 2'b01;  // AR exponent, sign-extended
  localparam logic [1:0] SCAD_A_POS   = 2'b10;  // byte pointer P field
  localparam logic [1:0] SCAD_A_MAGIC = 2'b11;

  // SCAD B mux select codes
  localparam logic [1:0] SCAD_B_SC     = 2'b00;
  localparam logic [1:0] SCAD_B_SIZE   = 2'b01;  // byte pointer S field
  localparam logic [1:0] SCAD_B_ESHIFT = 2'b10;  // effective-address shift count
  localparam logic [1:0] SCAD_B_MAGIC  = 2'b11;

  // SCAD function codes
  localparam logic [2:0] SCAD_F_A   = 3'b000;
  localparam logic [2:0] SCAD_F_ADD = 3'b001;
  localparam logic [2:0] SCAD_F_SUB = 3'b010;
  localparam logic [2:0] SCAD_F_INC = 3'b011;
  localparam logic [2:0] SCAD_F_DEC = 3'b100;
  localparam logic [2:0] SCAD_F_B   = 3'b101;
  localparam logic [2:0] SCAD_F_OR  = 3'b110;
  localparam logic [2:0] SCAD_F_AND = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } loop_state_e;

endpackage

// File: rtl/scad_alu.sv
// SCAD adder: A/B operand muxes feeding an 8-function 10-bit adder/logic unit.
// Latency: purely combinational, result valid in the same cycle as the selects.
// Backpressure: none; output follows inputs every cycle.
//
// Ports: ar (AR[0:35] as ar[35:0]), magic (magic[0:8] as magic[8:0]),
//        asel/bsel/func selects, fe/sc current register values, scad_out result.
module scad_alu
  import scd_pkg::*;
(
  input  logic [35:0] ar,
  input  logic [8:0]  magic,
  input  logic [1:0]  asel,
  input  logic [1:0]  bsel,
  input  logic [2:0]  func,
  input  word_t       fe,
  input  word_t       sc,
  output word_t       scad_out
);

  word_t a_op;
  word_t b_op;

  // Magic field is 9 bits; its top bit is replicated as the 10-bit sign.
  word_t magic_ext;
  assign magic_ext = {magic[8], magic};

  // AR[12:17] and AR[19:26] never reach the SCAD.
  logic unused_ar;
  assign unused_ar = ^{ar[23:18], ar[16:9]};

  always_comb begin
    a_op = '0;
    case (asel)
      SCAD_A_FE:    a_op = fe;
      SCAD_A_EXP:   a_op = {ar[35], ar[35], ar[34:27]};  // {AR0,AR0,AR1..8}
      SCAD_A_POS:   a_op = {4'b0, ar[35:30]};            // AR0..5
      SCAD_A_MAGIC: a_op = magic_ext;
      default:      a_op = '0;
    endcase
  end

  always_comb begin
    b_op = '0;
    case (bsel)
      SCAD_B_SC:     b_op = sc;
      SCAD_B_SIZE:   b_op = {4'b0, ar[29:24]};           // AR6..11
      SCAD_B_ESHIFT: b_op = {ar[17], ar[8:0]};           // {AR18, AR27..35}
      SCAD_B_MAGIC:  b_op = magic_ext;
      default:       b_op = '0;
    endcase
  end

  // All arithmetic wraps at 10 bits; carry-out and overflow are dropped.
  always_comb begin
    scad_out = '0;
    case (func)
      SCAD_F_A:   scad_out = a_op;
      SCAD_F_ADD: scad_out = a_op + b_op;
      SCAD_F_SUB: scad_out = a_op - b_op;
      SCAD_F_INC: scad_out = a_op + word_t'(1);
      SCAD_F_DEC: scad_out = a_op - word_t'(1);
      SCAD_F_B:   scad_out = b_op;
      SCAD_F_OR:  scad_out = a_op | b_op;
      SCAD_F_AND: scad_out = a_op & b_op;
      default:    scad_out = '0;
    endcase
  end

endmodule

// File: rtl/scd_shift_counter.sv
// Shift-count / floating-exponent unit: SC and FE registers, counted step loop, shift clamp.
// Latency: SC/FE update one edge after load/step; status outputs combinational from registers.
// Backpressure: none; loopAbort kills the loop immediately, scLoad is ignored while RUN.
//
// Ports: clk, rst_n (async active-low); AR[0:35], magic[0:8], SCAD selects,
//        scLoad/feLoad, loopStart/loopAbort in; scadOut, SC, FE, signs, scadZero,
//        shiftAmt, scGE36, loopBusy/loopStep/loopDone out.
module scd_shift_counter
  import scd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [35:0] AR,
  input  logic [8:0]  magic,
  input  logic [1:0]  scadAsel,
  input  logic [1:0]  scadBsel,
  input  logic [2:0]  scadFunc,
  input  logic        scLoad,
  input  logic        feLoad,
  input  logic        loopStart,
  input  logic        loopAbort,
  output logic [9:0]  scadOut,
  output logic [9:0]  SC,
  output logic [9:0]  FE,
  output logic        scSign,
  output logic        feSign,
  output logic        scadZero,
  output logic [5:0]  shiftAmt,
  output logic        scGE36,
  output logic        loopBusy,
  output logic        loopStep,
  output logic        loopDone
);

  word_t       sc_q, sc_d;
  word_t       fe_q, fe_d;
  loop_state_e state_q, state_d;
  word_t       scad_out;
  logic        sc_pos;
  logic        busy;
  logic        step;
  logic        done;

  scad_alu u_scad_alu (
    .ar       (AR),
    .magic    (magic),
    .asel     (scadAsel),
    .bsel     (scadBsel),
    .func     (scadFunc),
    .fe       (fe_q),
    .sc       (sc_q),
    .scad_out (scad_out)
  );

  // Strictly positive: sign clear and not zero.
  assign sc_pos = ~sc_q[W-1] & (sc_q != '0);
  assign busy   = (state_q == RUN);

  // Loop sequencer. Abort overrides every other transition, including a
  // same-cycle start, and suppresses the step so SC keeps its value.
  always_comb begin
    state_d = state_q;
    step    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (loopStart) state_d = RUN;
      end
      RUN: begin
        if (sc_pos) begin
          step = ~loopAbort;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;  // a start here is deliberately dropped
      end
      default: state_d = IDLE;
    endcase
    if (loopAbort) state_d = IDLE;
  end

  // SC: loop decrement wins; a load is only honoured outside RUN. A load in
  // the same cycle as a start lands first, so RUN counts from the new value.
  always_comb begin
    sc_d = sc_q;
    if (busy && sc_pos && !loopAbort) begin
      sc_d = sc_q - word_t'(1);
    end else if (scLoad && !busy) begin
      sc_d = scad_out;
    end
  end

  always_comb begin
    fe_d = fe_q;
    if (feLoad) fe_d = scad_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_q    <= '0;
      fe_q    <= '0;
      state_q <= IDLE;
    end else begin
      sc_q    <= sc_d;
      fe_q    <= fe_d;
      state_q <= state_d;
    end
  end

  // Shift clamp: negative counts shift by nothing, large ones saturate.
  logic ge_max;
  assign ge_max = ~sc_q[W-1] & (sc_q >= word_t'(SHMAX));

  always_comb begin
    shiftAmt = sc_q[5:0];
    if (sc_q[W-1]) begin
      shiftAmt = '0;
    end else if (ge_max) begin
      shiftAmt = 6'(SHMAX);
    end
  end

  assign scadOut  = scad_out;
  assign scadZero = (scad_out == '0);
  assign SC       = sc_q;
  assign FE       = fe_q;
  assign scSign   = sc_q[W-1];
  assign feSign   = fe_q[W-1];
  assign scGE36   = ge_max;
  assign loopBusy = busy;
  assign loopStep = step;
  assign loopDone = done;

endmodule

// File: tb/tb_scd_shift_counter.sv
module tb_scd_shift_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [35:0] ar = '0;
  logic [8:0]  magic = '0;
  logic [1:0]  asel = '0;
  logic [1:0]  bsel = '0;
  logic [2:0]  func = '0;
  logic        sc_load = 1'b0;
  logic        fe_load = 1'b0;
  logic        loop_start = 1'b0;
  logic        loop_abort = 1'b0;
  logic [9:0]  scad_out, sc, fe;
  logic        sc_sign, fe_sign, scad_zero, sc_ge36;
  logic [5:0]  shift_amt;
  logic        loop_busy, loop_step, loop_done;

  int total = 0;
  int bad   = 0;
  int m_sc  = 0;   // reference SC, 0..1023
  int m_fe  = 0;   // reference FE, 0..1023

  always #5 clk = ~clk;

  scd_shift_counter dut (
    .clk(clk), .rst_n(rst_n), .AR(ar), .magic(magic),
    .scadAsel(asel), .scadBsel(bsel), .scadFunc(func),
    .scLoad(sc_load), .feLoad(fe_load),
    .loopStart(loop_start), .loopAbort(loop_abort),
    .scadOut(scad_out), .SC(sc), .FE(fe),
    .scSign(sc_sign), .feSign(fe_sign), .scadZero(scad_zero),
    .shiftAmt(shift_amt), .scGE36(sc_ge36),
    .loopBusy(loop_busy), .loopStep(loop_step), .loopDone(loop_done)
  );

  // ---------------- reference model (machine bit numbering, integers) -----
  // Field AR[a:b] with bit 0 as the most significant of 36.
  function automatic int fld(logic [35:0] w, int a, int b);
    logic [35:0] t;
    t = w >> (35 - b);
    return int'(t) & ((1 << (b - a + 1)) - 1);
  endfunction

  function automatic int sext9(int v);
    return (v >= 256) ? v - 512 : v;
  endfunction

  function automatic int to_signed(int v);
    return (v >= 512) ? v - 1024 : v;
  endfunction

  function automatic int ref_scad(logic [35:0] w, logic [8:0] mg, int as, int bs, int fn,
                                  int cur_fe, int cur_sc);
    int a, b, r;
    case (as)
      0: a = cur_fe;
      1: a = sext9(fld(w, 0, 8)) & 1023;
      2: a = fld(w, 0, 5);
      default: a = sext9(int'(mg)) & 1023;
    endcase
    case (bs)
      0: b = cur_sc;
      1: b = fld(w, 6, 11);
      2: b = fld(w, 18, 18) * 512 + fld(w, 27, 35);
      default: b = sext9(int'(mg)) & 1023;
    endcase
    case (fn)
      0: r = a;
      1: r = a + b;
      2: r = a - b;
      3: r = a + 1;
      4: r = a - 1;
      5: r = b;
      6: r = a | b;
      default: r = a & b;
    endcase
    return r & 1023;
  endfunction

  function automatic int ref_amt(int v);
    int s;
    s = to_signed(v);
    if (s < 0) return 0;
    if (s >= 36) return 36;
    return s;
  endfunction

  // ---------------- helpers ------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load SC from the magic field (A = magic, func = A); range -256..255.
  task automatic load_sc(int v);
    logic [31:0] vv;
    vv = v;
    asel = 2'b11; func = 3'b000; magic = vv[8:0];
    sc_load = 1'b1;
    tick();
    sc_load = 1'b0;
    m_sc = v & 1023;
  endtask

  // Run a loop from the current SC. Cycle 0 is the start cycle. Optionally
  // pulse scLoad in cycle 'poke' (must be inside RUN) and/or raise loopStart
  // in the done cycle; neither may disturb the loop.
  task automatic run_loop(string nm, int poke, bit start_in_done);
    int n, done_cyc;
    bit e_step, e_done, e_busy;
    n = to_signed(m_sc);
    done_cyc = (n > 0) ? n + 2 : 2;
    loop_start = 1'b1;
    tick();
    loop_start = 1'b0;
    for (int k = 1; k <= done_cyc + 2; k++) begin
      if (k == poke) begin
        asel = 2'b11; func = 3'b000; magic = 9'd100; sc_load = 1'b1;
      end
      if (start_in_done && k == done_cyc) loop_start = 1'b1;
      #1;
      e_step = (n > 0) && (k <= n);
      e_done = (k == done_cyc);
      e_busy = (k < done_cyc);
      total++;
      if (loop_step !== e_step || loop_done !== e_done || loop_busy !== e_busy) begin
        bad++;
        $display("FAIL %s cyc%0d: step/done/busy got %b%b%b want %b%b%b",
                 nm, k, loop_step, loop_done, loop_busy, e_step, e_done, e_busy);
      end
      tick();
      sc_load = 1'b0;
      loop_start = 1'b0;
      if (e_step) m_sc = (m_sc - 1) & 1023;
    end
    total++;
    if (int'(sc) !== m_sc) begin
      bad++;
      $display("FAIL %s final SC: got %0d want %0d", nm, sc, m_sc);
    end
  endtask

  // ---------------- scenarios ----------------------------------------------
  task automatic test_reset();
    #3;
    total++;
    if (sc !== 10'd0 || fe !== 10'd0 || loop_busy !== 1'b0 || loop_done !== 1'b0 ||
        loop_step !== 1'b0 || shift_amt !== 6'd0 || sc_ge36 !== 1'b0 ||
        sc_sign !== 1'b0 || fe_sign !== 1'b0) begin
      bad++;
      $display("FAIL reset: SC=%0d FE=%0d busy=%b done=%b step=%b amt=%0d ge=%b want all 0",
               sc, fe, loop_busy, loop_done, loop_step, shift_amt, sc_ge36);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    m_sc = 0; m_fe = 0;
  endtask

  task automatic test_scad_random();
    int exp_o, as, bs, fn;
    for (int i = 0; i < 300; i++) begin
      ar    = {$urandom, $urandom};
      magic = 9'($urandom);
      as = $urandom_range(3); bs = $urandom_range(3); fn = $urandom_range(7);
      asel = 2'(as); bsel = 2'(bs); func = 3'(fn);
      sc_load = ($urandom_range(3) == 0);
      fe_load = ($urandom_range(3) == 0);
      #1;
      exp_o = ref_scad(ar, magic, as, bs, fn, m_fe, m_sc);
      total++;
      if (int'(scad_out) !== exp_o || scad_zero !== (exp_o == 0)) begin
        bad++;
        $display("FAIL scad %0d a%0d b%0d f%0d: got %0d z%b want %0d",
                 i, as, bs, fn, scad_out, scad_zero, exp_o);
      end
      tick();
      if (sc_load) m_sc = exp_o;
      if (fe_load) m_fe = exp_o;
      sc_load = 1'b0; fe_load = 1'b0;
      total++;
      if (int'(sc) !== m_sc || int'(fe) !== m_fe ||
          sc_sign !== m_sc[9] || fe_sign !== m_fe[9]) begin
        bad++;
        $display("FAIL regs %0d: SC=%0d FE=%0d want SC=%0d FE=%0d", i, sc, fe, m_sc, m_fe);
      end
    end
  endtask

  task automatic test_fe_exp();
    ar = '0;
    ar[34:27] = 8'o200;          // AR[1:8]
    magic = 9'o600;              // -128
    asel = 2'b01; bsel = 2'b11; func = 3'b001;
    fe_load = 1'b1;
    #1;
    total++;
    if (scad_out !== 10'd0 || scad_zero !== 1'b1) begin
      bad++;
      $display("FAIL fe_exp scad: got %0d z%b want 0 z1", scad_out, scad_zero);
    end
    tick();
    fe_load = 1'b0;
    m_fe = 0;
    total++;
    if (fe !== 10'd0) begin
      bad++;
      $display("FAIL fe_exp FE: got %0d want 0", fe);
    end
  endtask

  task automatic test_shift_amt();
    int vals[3] = '{50, -3, 17};
    for (int i = 0; i < 3 + 20; i++) begin
      int v;
      v = (i < 3) ? vals[i] : int'($urandom_range(511)) - 256;
      load_sc(v);
      #1;
      total++;
      if (int'(shift_amt) !== ref_amt(m_sc) || sc_ge36 !== (to_signed(m_sc) >= 36)) begin
        bad++;
        $display("FAIL shift_amt SC=%0d: got %0d ge%b want %0d", v, shift_amt, sc_ge36,
                 ref_amt(m_sc));
      end
    end
  endtask

  task automatic test_loop_count();
    // Directed: magic 5 through the SCAD, start on the following cycle.
    load_sc(5);
    run_loop("loop5", 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      load_sc(int'($urandom_range(12, 1)));
      run_loop("loop_rand", 0, 1'b0);
    end
    // scLoad during RUN must not disturb the count.
    load_sc(6);
    run_loop("loop_ignore_load", 3, 1'b0);
  endtask

  task automatic test_loop_nonpos();
    load_sc(0);
    run_loop("loop_zero", 0, 1'b0);
    load_sc(-1);
    run_loop("loop_neg1", 0, 1'b1);
    total++;
    if (sc !== 10'h3FF) begin
      bad++;
      $display("FAIL loop_neg1 SC: got %h want 3ff", sc);
    end
  endtask

  task automatic test_abort();
    load_sc(40);
    loop_start = 1'b1;
    tick();
    loop_start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) loop_abort = 1'b1;
      #1;
      total++;
      if (loop_step !== (k < 3)) begin
        bad++;
        $display("FAIL abort step cyc%0d: got %b want %b", k, loop_step, k < 3);
      end
      tick();
      if (k < 3) m_sc = (m_sc - 1) & 1023;
    end
    loop_abort = 1'b0;
    total++;
    if (int'(sc) !== m_sc || m_sc !== 38 || loop_busy !== 1'b0) begin
      bad++;
      $display("FAIL abort state: SC=%0d busy=%b want SC=38 busy=0", sc, loop_busy);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (loop_done !== 1'b0 || loop_busy !== 1'b0) begin
        bad++;
        $display("FAIL abort after cyc%0d: done=%b busy=%b want 0 0", k, loop_done, loop_busy);
      end
      tick();
    end
    // Abort in the same cycle as a start: never enters RUN.
    loop_start = 1'b1; loop_abort = 1'b1;
    tick();
    loop_start = 1'b0; loop_abort = 1'b0;
    total++;
    if (loop_busy !== 1'b0 || int'(sc) !== 38) begin
      bad++;
      $display("FAIL abort_vs_start: busy=%b SC=%0d want 0 38", loop_busy, sc);
    end
  endtask

  task automatic test_back_to_back();
    // Load and start in the same cycle: RUN counts from the new value.
    asel = 2'b11; func = 3'b000; magic = 9'd3;
    sc_load = 1'b1; loop_start = 1'b1;
    tick();
    sc_load = 1'b0; loop_start = 1'b0;
    m_sc = 3;
    for (int k = 1; k <= 6; k++) begin
      #1;
      total++;
      if (loop_step !== (k <= 3) || loop_done !== (k == 5)) begin
        bad++;
        $display("FAIL b2b cyc%0d: step=%b done=%b want %b %b", k, loop_step, loop_done,
                 k <= 3, k == 5);
      end
      tick();
    end
    total++;
    if (sc !== 10'd0) begin
      bad++;
      $display("FAIL b2b SC: got %0d want 0", sc);
    end
    m_sc = 0;
  endtask

  task automatic test_async_reset();
    // Give FE a nonzero value so the reset clearing it is visible.
    asel = 2'b11; func = 3'b000; magic = 9'd77; fe_load = 1'b1;
    tick();
    fe_load = 1'b0;
    load_sc(20);
    loop_start = 1'b1;
    tick();
    loop_start = 1'b0;
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (sc !== 10'd0 || fe !== 10'd0 || loop_busy !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: SC=%0d FE=%0d busy=%b want 0 0 0", sc, fe, loop_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      tick();
      total++;
      if (loop_done !== 1'b0 || loop_busy !== 1'b0 || sc !== 10'd0) begin
        bad++;
        $display("FAIL post_reset cyc%0d: done=%b busy=%b SC=%0d want 0 0 0",
                 k, loop_done, loop_busy, sc);
      end
    end
    m_sc = 0; m_fe = 0;
  endtask

  initial begin
    test_reset();
    test_scad_random();
    test_fe_exp();
    test_shift_amt();
    test_loop_count();
    test_loop_nonpos();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
